// File: rtl/spike_dec_pkg.sv
// Shared types and default sizing for the spike rate decoder.
package spike_dec_pkg;

  localparam int unsigned NUM_CH_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned WIN_W_DEF  = 8;

  typedef enum logic {IDLE, ACCUM} acc_state_t;
  typedef enum logic {RO_IDLE, RO_SEND} ro_state_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Valid/ready readout stream carrying one (channel, count) word per beat.
interface spike_rate_decoder_if
  import spike_dec_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) ();
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic             out_valid;
  logic             out_ready;
  logic [CH_W-1:0]  out_ch;
  logic [CNT_W-1:0] out_count;

  modport master (output out_valid, output out_ch, output out_count, input out_ready);
  modport slave  (input out_valid, input out_ch, input out_count, output out_ready);
endinterface

// File: rtl/spike_counter.sv
// One saturating spike accumulator; sum_c is the saturated count including this cycle's spike.
module spike_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             clear,
  input  logic             load_leak,
  output logic [CNT_W-1:0] sum_c
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    sum_c = (inc && (count_q != '1)) ? count_q + CNT_W'(1) : count_q;
  end

  // clear wins over leak-load, which wins over plain accumulation
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load_leak) begin
      count_d = sum_c >> 1;
    end else if (en) begin
      count_d = sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed per-channel spike counter with snapshot and valid/ready channel-by-channel readout.
// Build option SPIKE_DEC_LEAKY_EN: window end reloads accumulators with half the snapshot.
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int unsigned NUM_CH = NUM_CH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [NUM_CH-1:0]    spike_in,
  spike_rate_decoder_if.master rd,
  output logic                 window_done,
  output logic                 overrun
);
  localparam int unsigned CH_W = $clog2(NUM_CH);
`ifdef SPIKE_DEC_LEAKY_EN
  localparam bit LEAKY = 1'b1;
`else
  localparam bit LEAKY = 1'b0;
`endif

  acc_state_t       acc_state_q, acc_state_d;
  ro_state_t        ro_state_q, ro_state_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] snap_q [NUM_CH];
  logic [CNT_W-1:0] snap_d [NUM_CH];
  logic [CNT_W-1:0] sum_c  [NUM_CH];
  logic             out_valid_q, out_valid_d;
  logic [CH_W-1:0]  out_ch_q, out_ch_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             window_done_q, window_done_d;
  logic             overrun_q, overrun_d;
  logic             cnt_en_c, cnt_clr_c, cnt_leak_c, win_end_c;
  logic             hs_c, last_hs_c, take_c;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (cnt_en_c),
      .inc       (spike_in[g]),
      .clear     (cnt_clr_c),
      .load_leak (cnt_leak_c),
      .sum_c     (sum_c[g])
    );
  end

  // Accumulation FSM: window timing and counter control
  always_comb begin
    acc_state_d = acc_state_q;
    rem_d       = rem_q;
    cnt_en_c    = 1'b0;
    cnt_clr_c   = 1'b0;
    cnt_leak_c  = 1'b0;
    win_end_c   = 1'b0;
    case (acc_state_q)
      IDLE: begin
        cnt_clr_c = 1'b1;
        if (enable) begin
          acc_state_d = ACCUM;
          rem_d       = win_len;
        end
      end
      ACCUM: begin
        if (!enable) begin
          acc_state_d = IDLE;
          cnt_clr_c   = 1'b1;
          rem_d       = '0;
        end else begin
          cnt_en_c = 1'b1;
          // a loaded 0 wraps through 2^WIN_W-1, giving the full-length window
          if (rem_q == WIN_W'(1)) begin
            win_end_c = 1'b1;
            rem_d     = win_len;
            if (LEAKY) cnt_leak_c = 1'b1;
            else       cnt_clr_c  = 1'b1;
          end else begin
            rem_d = rem_q - WIN_W'(1);
          end
        end
      end
      default: acc_state_d = IDLE;
    endcase
  end

  // Readout FSM: snapshot capture, streaming and overrun detection
  always_comb begin
    ro_state_d    = ro_state_q;
    out_valid_d   = out_valid_q;
    out_ch_d      = out_ch_q;
    out_count_d   = out_count_q;
    window_done_d = 1'b0;
    overrun_d     = overrun_q;
    snap_d        = snap_q;
    hs_c          = out_valid_q && rd.out_ready;
    last_hs_c     = hs_c && (ro_state_q == RO_SEND) && (out_ch_q == CH_W'(NUM_CH - 1));
    take_c        = win_end_c && ((ro_state_q == RO_IDLE) || last_hs_c);
    if (take_c) begin
      snap_d        = sum_c;
      ro_state_d    = RO_SEND;
      out_valid_d   = 1'b1;
      out_ch_d      = '0;
      out_count_d   = sum_c[0];
      window_done_d = 1'b1;
    end else if (ro_state_q == RO_SEND) begin
      if (win_end_c) overrun_d = 1'b1;
      if (last_hs_c) begin
        ro_state_d  = RO_IDLE;
        out_valid_d = 1'b0;
        out_ch_d    = '0;
      end else if (hs_c) begin
        out_ch_d    = out_ch_q + CH_W'(1);
        out_count_d = snap_q[out_ch_q + CH_W'(1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_state_q   <= IDLE;
      ro_state_q    <= RO_IDLE;
      rem_q         <= '0;
      out_valid_q   <= 1'b0;
      out_ch_q      <= '0;
      out_count_q   <= '0;
      window_done_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) snap_q[i] <= '0;
    end else begin
      acc_state_q   <= acc_state_d;
      ro_state_q    <= ro_state_d;
      rem_q         <= rem_d;
      out_valid_q   <= out_valid_d;
      out_ch_q      <= out_ch_d;
      out_count_q   <= out_count_d;
      window_done_q <= window_done_d;
      overrun_q     <= overrun_d;
      snap_q        <= snap_d;
    end
  end

  assign rd.out_valid = out_valid_q;
  assign rd.out_ch    = out_ch_q;
  assign rd.out_count = out_count_q;
  assign window_done  = window_done_q;
  assign overrun      = overrun_q;
endmodule
